// File: rtl/filter_pkg.sv
// Types and constants shared by the filter stage and its result writer.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        BURST  = 2'd2,
        FINISH = 2'd3
    } wr_state_t;

    localparam int WORD_BYTES         = 4;
    localparam int DEFAULT_BURST_LEN  = 4;
    localparam int DEFAULT_FIFO_DEPTH = 8;
    localparam int DEFAULT_FRAME_W    = 20;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even when a pop happens that cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/filter_result_writer.sv
// Collects filter results in a FIFO and writes them back to the frame buffer
// as fixed-length bursts from an incrementing address.
module filter_result_writer
    import filter_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN,
    parameter int FRAME_W    = DEFAULT_FRAME_W
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [FRAME_W-1:0] frame_words,
    input  logic               pix_valid,
    input  logic [31:0]        pix_data,
    output logic               pix_ready,
    output logic               wr_req,
    output logic [31:0]        wr_addr,
    output logic [31:0]        wr_data,
    input  logic               wr_ack,
    output logic               busy,
    output logic               done,
    output logic               overflow_err
);

    localparam int                 CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FRAME_W-1:0] BURST_W = FRAME_W'(BURST_LEN);
    localparam logic [31:0]        STEP    = 32'(WORD_BYTES);

    wr_state_t          state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [FRAME_W-1:0] remaining_q, remaining_d;
    logic [FRAME_W-1:0] target_q, target_d;
    logic [FRAME_W-1:0] accepted_q, accepted_d;
    logic [FRAME_W-1:0] beat_cnt_q, beat_cnt_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [31:0]        fifo_rdata;
    logic [FRAME_W-1:0] burst_len;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .pop   (pop),
        .wdata (pix_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Ready depends on registered state only, so push and pop may coincide.
    assign pix_ready    = (state_q != IDLE) && !fifo_full && (accepted_q < target_q);
    assign push         = pix_valid && pix_ready;
    assign wr_req       = (state_q == BURST);
    assign pop          = wr_req && wr_ack;
    assign wr_addr      = addr_q;
    assign wr_data      = (wr_req && !fifo_empty) ? fifo_rdata : '0;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign overflow_err = overflow_q;

    assign burst_len = (remaining_q < BURST_W) ? remaining_q : BURST_W;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        target_d    = target_q;
        accepted_d  = accepted_q;
        beat_cnt_d  = beat_cnt_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;

        if (push) begin
            accepted_d = accepted_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pix_valid) begin
                    overflow_d = 1'b1;
                end
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = frame_words;
                    target_d    = frame_words;
                    accepted_d  = '0;
                    overflow_d  = pix_valid;
                    state_d     = (frame_words == '0) ? FINISH : WAIT;
                end
            end
            WAIT: begin
                if (FRAME_W'(fifo_count) >= burst_len) begin
                    beat_cnt_d = burst_len;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (wr_ack) begin
                    beat_cnt_d  = beat_cnt_q - 1'b1;
                    addr_d      = addr_q + STEP;
                    remaining_d = remaining_q - 1'b1;
                    // Leaving BURST after every burst guarantees a wr_req gap.
                    if (beat_cnt_q == FRAME_W'(1)) begin
                        state_d = (remaining_q == FRAME_W'(1)) ? FINISH : WAIT;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            target_q    <= '0;
            accepted_q  <= '0;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            target_q    <= target_d;
            accepted_q  <= accepted_d;
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_filter_result_writer.sv
// Scoreboard bench: accepted words queue their expected beat, a negedge
// monitor pops and compares every acknowledged write beat.
module tb_filter_result_writer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [19:0] frame_words = '0;
    logic        pix_valid = 1'b0;
    logic [31:0] pix_data = '0;
    logic        pix_ready;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow_err;

    filter_result_writer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .base_addr    (base_addr),
        .frame_words  (frame_words),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [63:0] expq[$];
    int          seen_bursts[$];
    logic        took;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    // Monitor: scoreboard pops, hold stability, burst lengths, done pulses.
    logic        hold_flag = 1'b0;
    logic [31:0] hold_addr, hold_data;
    logic        prev_req = 1'b0;
    int          beats = 0;
    always @(negedge clk) begin
        if (!n_rst) begin
            hold_flag = 1'b0;
            prev_req  = 1'b0;
            beats     = 0;
        end else begin
            if (hold_flag) begin
                chk("hold_req", 64'(wr_req), 64'd1);
                chk("hold_addr", 64'(wr_addr), 64'(hold_addr));
                chk("hold_data", 64'(wr_data), 64'(hold_data));
            end
            if (wr_req && wr_ack) begin
                if (expq.size() == 0) begin
                    timeout_fail("unexpected_beat");
                end else begin
                    logic [63:0] e;
                    e = expq.pop_front();
                    chk("beat_addr", 64'(wr_addr), 64'(e[63:32]));
                    chk("beat_data", 64'(wr_data), 64'(e[31:0]));
                end
                beats++;
            end
            if (prev_req && !wr_req) begin
                seen_bursts.push_back(beats);
                beats = 0;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
            hold_flag = wr_req && !wr_ack;
            hold_addr = wr_addr;
            hold_data = wr_data;
            prev_req  = wr_req;
        end
    end

    // One clock: drive after the edge, sample at negedge, return just after the next edge.
    task automatic step(input logic v, input logic [31:0] d, input logic ack, input logic [31:0] exp_addr);
        pix_valid = v;
        pix_data  = d;
        wr_ack    = ack;
        @(negedge clk);
        took = v && pix_ready;
        if (took) expq.push_back({exp_addr, d});
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [31:0] base, input int n, input logic ack);
        base_addr   = base;
        frame_words = 20'(n);
        start       = 1'b1;
        step(1'b0, 32'h0, ack, 32'h0);
        start       = 1'b0;
    endtask

    task automatic feed(input logic [31:0] base, input logic [15:0] tag, input int first,
                        input int n, input int ack_hold, input bit mid_start);
        int idx = first;
        int cyc = 0;
        bit fired = 1'b0;
        while (idx < n && cyc < 400) begin
            if (mid_start && !fired && wr_req) begin
                start       = 1'b1;
                base_addr   = 32'hDEAD_0000;
                frame_words = 20'd3;
                fired       = 1'b1;
            end
            step(1'b1, {tag, 16'(idx)}, logic'(cyc >= ack_hold), base + 32'(idx * 4));
            start = 1'b0;
            if (took) idx++;
            cyc++;
        end
        pix_valid = 1'b0;
        if (idx < n) timeout_fail("feed");
    endtask

    task automatic drain();
        int cyc = 0;
        while (busy && cyc < 200) begin
            step(1'b0, 32'h0, 1'b1, 32'h0);
            cyc++;
        end
        if (busy) timeout_fail("drain");
        step(1'b0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h0);
    endtask

    task automatic frame_end(input string name, input int n, input int done_before);
        int exp_b[$];
        int rem = n;
        while (rem > 0) begin
            int b = (rem < 4) ? rem : 4;
            exp_b.push_back(b);
            rem -= b;
        end
        chk({name, "_done_pulses"}, 64'(done_cnt - done_before), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_leftover"}, 64'(expq.size()), 64'd0);
        chk({name, "_bursts"}, 64'(seen_bursts.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < seen_bursts.size(); i++)
            chk({name, "_burst_len"}, 64'(seen_bursts[i]), 64'(exp_b[i]));
        seen_bursts.delete();
        $display("frame %s: %0d words, %0d bursts", name, n, exp_b.size());
    endtask

    initial begin
        int d0;
        int idx;

        #2;
        chk("rst_ctl", 64'({pix_ready, wr_req, busy, done, overflow_err}), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Basic frame: two full bursts from 0x1000.
        d0 = done_cnt;
        begin_frame(32'h1000, 8, 1'b1);
        feed(32'h1000, 16'hA1, 0, 8, 0, 1'b0);
        drain();
        frame_end("basic", 8, d0);

        // Short tail: 4 + 2 beats.
        d0 = done_cnt;
        begin_frame(32'h1400, 6, 1'b1);
        feed(32'h1400, 16'hB2, 0, 6, 0, 1'b0);
        chk("tail_ready_low", 64'(pix_ready), 64'd0);
        chk("tail_still_busy", 64'(busy), 64'd1);
        drain();
        frame_end("tail", 6, d0);

        // Backpressure: no ack for 20 cycles, FIFO fills to its depth.
        d0 = done_cnt;
        begin_frame(32'h2000, 12, 1'b0);
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, {16'hC3, 16'(idx)}, 1'b0, 32'h2000 + 32'(idx * 4));
            if (took) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd8);
        chk("bp_ready_low", 64'(pix_ready), 64'd0);
        chk("bp_req_held", 64'(wr_req), 64'd1);
        feed(32'h2000, 16'hC3, idx, 12, 0, 1'b0);
        drain();
        frame_end("backpressure", 12, d0);

        // Simultaneous push/pop around the full boundary.
        d0 = done_cnt;
        begin_frame(32'h3000, 16, 1'b0);
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            step(1'b1, {16'hD4, 16'(idx)}, 1'b0, 32'h3000 + 32'(idx * 4));
            if (took) idx++;
        end
        chk("pp_seven", 64'(idx), 64'd7);
        chk("pp_count7", 64'(dut.u_fifo.count), 64'd7);
        step(1'b1, {16'hD4, 16'(idx)}, 1'b1, 32'h3000 + 32'(idx * 4));
        chk("pp_push_with_pop", 64'(took), 64'd1);
        if (took) idx++;
        chk("pp_count_kept", 64'(dut.u_fifo.count), 64'd7);
        step(1'b1, {16'hD4, 16'(idx)}, 1'b0, 32'h3000 + 32'(idx * 4));
        if (took) idx++;
        chk("pp_count_full", 64'(dut.u_fifo.count), 64'd8);
        chk("pp_full_ready", 64'(pix_ready), 64'd0);
        step(1'b1, {16'hD4, 16'(idx)}, 1'b1, 32'h3000 + 32'(idx * 4));
        chk("pp_full_no_push", 64'(took), 64'd0);
        if (took) idx++;
        chk("pp_count_after", 64'(dut.u_fifo.count), 64'd7);
        feed(32'h3000, 16'hD4, idx, 16, 0, 1'b0);
        drain();
        frame_end("pushpop", 16, d0);

        // Zero-length frame.
        d0 = done_cnt;
        begin_frame(32'h4000, 0, 1'b1);
        chk("zero_finish_busy", 64'(busy), 64'd1);
        chk("zero_finish_done", 64'(done), 64'd0);
        chk("zero_no_req", 64'(wr_req), 64'd0);
        step(1'b0, 32'h0, 1'b1, 32'h0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_idle", 64'(busy), 64'd0);
        step(1'b0, 32'h0, 1'b1, 32'h0);
        chk("zero_done_once", 64'(done), 64'd0);
        chk("zero_pulses", 64'(done_cnt - d0), 64'd1);
        chk("zero_no_bursts", 64'(seen_bursts.size()), 64'd0);

        // start during BURST is ignored.
        d0 = done_cnt;
        begin_frame(32'h5000, 12, 1'b1);
        feed(32'h5000, 16'hE5, 0, 12, 0, 1'b1);
        drain();
        frame_end("midstart", 12, d0);

        // overflow_err: sticky while idle, cleared by start.
        chk("ovf_clear", 64'(overflow_err), 64'd0);
        step(1'b1, 32'h0BAD_0BAD, 1'b1, 32'h0);
        chk("ovf_not_taken", 64'(took), 64'd0);
        chk("ovf_set", 64'(overflow_err), 64'd1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 32'h0);
        chk("ovf_sticky", 64'(overflow_err), 64'd1);
        d0 = done_cnt;
        begin_frame(32'h6000, 4, 1'b1);
        chk("ovf_start_clears", 64'(overflow_err), 64'd0);
        feed(32'h6000, 16'hF6, 0, 4, 0, 1'b0);
        drain();
        frame_end("ovf", 4, d0);

        // Reset mid-burst, then a clean frame.
        begin_frame(32'h7000, 8, 1'b0);
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, {16'h77, 16'(idx)}, 1'b0, 32'h7000 + 32'(idx * 4));
            if (took) idx++;
        end
        chk("mid_req_before_rst", 64'(wr_req), 64'd1);
        pix_valid = 1'b0;
        d0 = done_cnt;
        #1;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_ctl", 64'({pix_ready, wr_req, busy, done, overflow_err}), 64'd0);
        chk("mid_rst_addr", 64'(wr_addr), 64'd0);
        chk("mid_rst_data", 64'(wr_data), 64'd0);
        expq.delete();
        seen_bursts.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (3) step(1'b0, 32'h0, 1'b1, 32'h0);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        d0 = done_cnt;
        begin_frame(32'h7100, 5, 1'b1);
        feed(32'h7100, 16'h88, 0, 5, 0, 1'b0);
        drain();
        frame_end("after_rst", 5, d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_result_writer.md
Name: filter_result_writer

Overview:
- Sink for the 32-bit pixel results produced by the filter stage (brightness or debayer, selected by filterMode).
- Buffers the results in a small FIFO and writes them back to the frame buffer as fixed-length bursts on a req/ack memory-write port.
- Generates incrementing addresses from a base address, tracks the frame length, and pulses done when the whole frame has been written.

Parameters:
- FIFO_DEPTH, 8: result FIFO entries; power of 2, must be >= BURST_LEN.
- BURST_LEN, 4: beats per write burst. The final burst of a frame may be shorter.
- FRAME_W, 20: width of the frame word counters.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr and frame_words; ignored unless the block is idle
- base_addr  in  32  byte address of the first result word; word aligned
- frame_words  in  FRAME_W  number of 32-bit results in the frame
- pix_valid  in  1  filter result valid
- pix_data  in  32  filter result word
- pix_ready  out  1  block accepts pix_data this cycle
- wr_req  out  1  write beat request
- wr_addr  out  32  byte address of the current beat
- wr_data  out  32  data of the current beat (FIFO head)
- wr_ack  in  1  memory accepts the current beat
- busy  out  1  high from the start cycle until done
- done  out  1  one-cycle pulse when the last beat is acknowledged
- overflow_err  out  1  sticky; set if pix_valid is asserted while idle; cleared by start

Behaviour:
- Reset: all outputs are 0, state is IDLE, FIFO is empty, all counters are 0. Reset mid-frame aborts the frame; no done pulse is issued.
- Input handshake:
  - A word transfers when pix_valid && pix_ready.
  - pix_ready = (state != IDLE) && !fifo_full && (accepted < frame_words).
  - pix_ready is computed from registered state only, so a push and a pop in the same cycle are both legal. The FIFO count is unchanged in that case.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- Output handshake:
  - A beat transfers when wr_req && wr_ack.
  - While wr_req is high, wr_addr and wr_data are held stable until wr_ack.
  - Each acknowledged beat pops the FIFO, adds 4 to addr, and decrements remaining.
- Latency: a word accepted in cycle N can appear on wr_data no earlier than cycle N+1.
- States:
  - IDLE: busy=0. On start: latch base_addr into addr; load remaining and the target from frame_words; clear accepted and overflow_err; go to WAIT. If frame_words==0, go to FINISH instead.
  - WAIT: compute burst = min(BURST_LEN, remaining). When fifo_count >= burst, load beat_cnt=burst and go to BURST.
  - BURST: wr_req=1. On each ack, decrement beat_cnt. On the ack with beat_cnt==1: go to FINISH if remaining becomes 0, otherwise go to WAIT. wr_req drops for at least one cycle between bursts.
  - FINISH: done=1 for exactly one cycle; busy drops in the same cycle; next state is IDLE.
- busy = (state != IDLE).
- start while busy is ignored; latched parameters are unchanged.
- Address arithmetic is 32-bit modulo, with no boundary checks. Counters are FRAME_W wide, unsigned.
- overflow_err: set in any IDLE cycle that has pix_valid=1. Data offered while idle is never accepted.

Decomposition:
- Shared package filter_pkg:
  - wr_state_t enum {IDLE, WAIT, BURST, FINISH}
  - WORD_BYTES = 4
  - Default BURST_LEN and FIFO_DEPTH constants, which the filter control registers also use.
- One sub-module, result_fifo: synchronous FIFO with ports push, pop, wdata, rdata (first-word fall-through), full, empty, count. It uses wrap-around pointers with an extra MSB for full/empty detection.
- FSM, counters and address generator stay in filter_result_writer.

Test Plan:
- Basic frame: start with base_addr=0x1000, frame_words=8, continuous pix_valid, wr_ack always 1 -> two 4-beat bursts at 0x1000..0x101C. Data appears in input order. Exactly one done pulse after the 8th ack, then busy=0.
- Short tail: frame_words=6 -> bursts of 4 then 2, last beat at base+0x14. pix_ready goes low after the 6th word is accepted.
- Backpressure: wr_ack held 0 for 20 cycles -> FIFO fills to 8, pix_ready=0, wr_addr/wr_data held stable. After wr_ack is released, all words drain in order with no loss or duplication.
- Simultaneous push/pop: FIFO holding 7 words, push and ack in the same cycle -> count stays 7 and ordering is preserved. With a full FIFO and an ack in the same cycle, no push is accepted that cycle.
- Edge commands: frame_words=0 -> done one cycle after FINISH is entered and no wr_req. start pulsed during BURST -> ignored, original frame completes.
- Errors and reset: pix_valid asserted in IDLE -> overflow_err=1 and stays set until the next start. n_rst asserted mid-burst -> all outputs 0 immediately, and a following start runs a clean frame.
